// File: rtl/axi_master.sv
// axi_master: single-outstanding AXI master turning a command/data stream into AXI bursts; define AXI_MASTER_TIMEOUT_EN for a response watchdog
module axi_master #(
  parameter int addr_width = 4,
  parameter int data_width = 32,
  parameter int len = 4,
  parameter int resp = 2,
  parameter int timeout = 64
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [addr_width-1:0] cmd_addr,
  input  logic [len-1:0]        cmd_len,
  input  logic [1:0]            cmd_burst,
  input  logic [data_width-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [data_width-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  rd_last,
  output logic                  done,
  output logic [resp-1:0]       done_resp,
  output logic [3:0]            awid,
  output logic [addr_width-1:0] awaddr,
  output logic [len-1:0]        awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic                  awlock,
  output logic [3:0]            awcache,
  output logic [2:0]            awprot,
  output logic [3:0]            awqos,
  output logic [3:0]            awregion,
  output logic                  awuser,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [3:0]            wid,
  output logic [data_width-1:0] wdata,
  output logic [3:0]            wstrb,
  output logic                  wlast,
  output logic                  wuser,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [resp-1:0]       bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic [3:0]            arid,
  output logic [addr_width-1:0] araddr,
  output logic [len-1:0]        arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic                  arlock,
  output logic [3:0]            arcache,
  output logic [2:0]            arprot,
  output logic [3:0]            arqos,
  output logic [3:0]            arregion,
  output logic                  aruser,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [data_width-1:0] rdata,
  input  logic [resp-1:0]       rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready
);
  typedef enum logic [2:0] {IDLE, WADDR, WDATA, WRESP, RADDR, RDATA} state_t;
  state_t state_q, state_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic [len-1:0] len_q, len_d, cnt_q, cnt_d;
  logic [1:0] burst_q, burst_d;
  logic done_q, done_d;
  logic [resp-1:0] done_resp_q, done_resp_d, rmax_q, rmax_d, rnew;
  logic illegal, to_hit;
  assign cmd_ready = state_q == IDLE;
  assign awvalid = state_q == WADDR;
  assign arvalid = state_q == RADDR;
  assign bready = state_q == WRESP;
  assign awaddr = addr_q;
  assign araddr = addr_q;
  assign awlen = len_q;
  assign arlen = len_q;
  assign awburst = burst_q;
  assign arburst = burst_q;
  assign {awid, arid, wid, awlock, arlock, awcache, arcache, awprot, arprot} = '0;
  assign {awqos, arqos, awregion, arregion, awuser, aruser, wuser} = '0;
  assign awsize = 3'b010;
  assign arsize = 3'b010;
  assign wstrb = 4'hF;
  assign wvalid = state_q == WDATA && wr_valid;
  assign wr_ready = state_q == WDATA && wready;
  assign wdata = state_q == WDATA ? wr_data : '0;
  assign wlast = state_q == WDATA && cnt_q == len_q;
  assign rready = state_q == RDATA && rd_ready;
  assign rd_valid = state_q == RDATA && rvalid;
  assign rd_data = state_q == RDATA ? rdata : '0;
  assign rd_last = state_q == RDATA && rlast;
  assign done = done_q;
  assign done_resp = done_resp_q;
  assign illegal = cmd_burst == 2'b11 || (cmd_burst == 2'b10 && !(cmd_len inside {1, 3, 7, 15}));
  assign rnew = rresp > rmax_q ? rresp : rmax_q;
`ifdef AXI_MASTER_TIMEOUT_EN
  localparam int tw = $clog2(timeout + 1);
  logic [tw-1:0] tcnt_q, tcnt_d;
  logic waiting;
  // watchdog: count consecutive cycles with no response valid while waiting on one
  always_comb begin
    waiting = (state_q == WRESP && !bvalid) || (state_q == RDATA && !rvalid);
    tcnt_d = waiting ? tcnt_q + 1'b1 : '0;
    to_hit = waiting && tcnt_q == tw'(timeout - 1);
  end
  // watchdog counter register
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) tcnt_q <= '0;
    else tcnt_q <= tcnt_d;
`else
  assign to_hit = timeout < 0;
`endif
  // next-state, capture of the command and completion response
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    len_d = len_q;
    burst_d = burst_q;
    cnt_d = cnt_q;
    rmax_d = rmax_q;
    done_d = 1'b0;
    done_resp_d = done_resp_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        if (illegal) begin
          done_d = 1'b1;
          done_resp_d = resp'(2);
        end else begin
          addr_d = cmd_addr;
          len_d = cmd_len;
          burst_d = cmd_burst;
          cnt_d = '0;
          rmax_d = '0;
          state_d = cmd_write ? WADDR : RADDR;
        end
      end
      WADDR: state_d = awready ? WDATA : WADDR;
      WDATA: if (wvalid && wready) begin
        cnt_d = cnt_q + 1'b1;
        state_d = wlast ? WRESP : WDATA;
      end
      WRESP: if (bvalid || to_hit) begin
        state_d = IDLE;
        done_d = 1'b1;
        done_resp_d = bvalid ? bresp : resp'(3);
      end
      RADDR: state_d = arready ? RDATA : RADDR;
      RDATA: if (rvalid && rready) begin
        rmax_d = rnew;
        if (rlast) begin
          state_d = IDLE;
          done_d = 1'b1;
          done_resp_d = rnew;
        end
      end else if (to_hit) begin
        state_d = IDLE;
        done_d = 1'b1;
        done_resp_d = resp'(3);
      end
      default: state_d = IDLE;
    endcase
  end
  // state and registered outputs
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      state_q <= IDLE;
      addr_q <= '0;
      len_q <= '0;
      burst_q <= '0;
      cnt_q <= '0;
      rmax_q <= '0;
      done_q <= 1'b0;
      done_resp_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      len_q <= len_d;
      burst_q <= burst_d;
      cnt_q <= cnt_d;
      rmax_q <= rmax_d;
      done_q <= done_d;
      done_resp_q <= done_resp_d;
    end
endmodule
